// File: rtl/pipe_stage_register.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// 2-entry skid buffer, synchronous flush and optional perf counters.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   defined   -> stall_count / flush_drop_count are saturating counters
//   undefined -> both counter ports are tied to 0
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             discard all held entries this cycle
//   in_valid/ready    upstream handshake (in_ready is registered)
//   in_data/ctrl      upstream payload
//   out_valid/ready   downstream handshake
//   out_data/ctrl     head entry (out_ctrl = CTRL_BUBBLE when invalid)
//   stall_count       cycles with out_valid && !out_ready
//   flush_drop_count  valid entries discarded by flush
module pipe_stage_register #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_drop_count
);

  // Encoding keeps bit0 = main valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   in_ready_q;

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic main_v;
  logic skid_v;
  logic in_xfer;
  logic out_xfer;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign main_v   = (state_q != ST_EMPTY);
  assign skid_v   = (state_q == ST_FULL);
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_v && out_ready;

  // Next-state and load selects. Flush overrides everything and
  // drops the concurrent input; an output transfer still counts
  // as delivered because downstream samples it at this edge.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d    = ST_BUSY;
            ld_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            ld_main_in = 1'b1;
          end else if (in_xfer) begin
            state_d = ST_FULL;
            ld_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid always drains to main before any newer entry.
          if (out_xfer) begin
            state_d      = ST_BUSY;
            ld_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (ld_main_in) begin
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end else if (ld_main_skid) begin
      main_data_d = skid_data_q;
      main_ctrl_d = skid_ctrl_q;
    end
    if (ld_skid) begin
      skid_data_d = in_data;
      skid_ctrl_d = in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_v ? main_ctrl_q : CTRL_BUBBLE;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] drop_q;
  logic [1:0]       drop_n;
  logic [CNT_W:0]   drop_sum;
  logic             stall;

  assign stall = main_v && !out_ready;

  // Entries lost to flush: main unless it left this cycle, plus skid.
  always_comb begin
    drop_n = 2'd0;
    if (flush) begin
      drop_n = {1'b0, main_v && !out_ready} + {1'b0, skid_v};
    end
  end

  assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (stall && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (drop_sum[CNT_W]) begin
        drop_q <= '1;
      end else begin
        drop_q <= drop_sum[CNT_W-1:0];
      end
    end
  end

  assign stall_count      = stall_q;
  assign flush_drop_count = drop_q;
`else
  assign stall_count      = '0;
  assign flush_drop_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// Directed self-checking bench for pipe_stage_register.
// Drives inputs 1ns after each rising edge and checks registered outputs.
module tb_pipe_stage_register;

  localparam logic [7:0] BUB = 8'hA5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [3:0]  stall_count;
  logic [3:0]  flush_drop_count;

  int n_total = 0;
  int n_pass  = 0;

  pipe_stage_register #(
    .DATA_W     (32),
    .CTRL_W     (8),
    .CTRL_BUBBLE(BUB),
    .CNT_W      (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_ctrl         (in_ctrl),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_ctrl        (out_ctrl),
    .stall_count     (stall_count),
    .flush_drop_count(flush_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag,
                         input logic [3:0] got,
                         input logic [3:0] exp);
`ifdef PIPE_STAGE_PERF_EN
    chk(tag, {28'd0, got}, {28'd0, exp});
`else
    chk(tag, {28'd0, got}, 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_ctrl   = 8'd0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ctrl", {24'd0, out_ctrl}, {24'd0, BUB});
    chk("rst_data", out_data, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk_cnt("rst_stall", stall_count, 4'd0);
    rst = 1'b0;

    // Streaming 1..8 at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      in_ctrl = 8'(8'h10 + i);
      step();
      chk("str_valid", {31'd0, out_valid}, 32'd1);
      chk("str_data", out_data, 32'(i));
      chk("str_ctrl", {24'd0, out_ctrl}, 32'(8'h10 + i));
      chk("str_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("str_end_valid", {31'd0, out_valid}, 32'd0);
    chk("str_end_ctrl", {24'd0, out_ctrl}, {24'd0, BUB});
    chk("str_end_data", out_data, 32'd8);

    // Back-pressure fills the skid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    in_ctrl   = 8'h01;
    step();
    chk("bp_a_data", out_data, 32'h11);
    chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
    in_data = 32'h22;
    in_ctrl = 8'h02;
    step();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_full_data", out_data, 32'h11);
    chk("bp_full_ctrl", {24'd0, out_ctrl}, 32'h01);
    in_valid = 1'b0;
    in_data  = 32'hDEAD;
    step();
    chk("bp_hold_data", out_data, 32'h11);
    chk("bp_hold_ctrl", {24'd0, out_ctrl}, 32'h01);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("drain_b_data", out_data, 32'h22);
    chk("drain_b_ctrl", {24'd0, out_ctrl}, 32'h02);
    chk("drain_b_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a pending input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h41;
    in_ctrl   = 8'h03;
    step();
    in_data = 32'h42;
    in_ctrl = 8'h04;
    step();
    chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
    flush   = 1'b1;
    in_data = 32'h33;
    in_ctrl = 8'h05;
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ctrl", {24'd0, out_ctrl}, {24'd0, BUB});
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_data_kept", out_data, 32'h41);
    chk_cnt("fl_drop2", flush_drop_count, 4'd2);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no_c", {31'd0, out_valid}, 32'd0);

    // Flush while the head is delivered.
    in_valid = 1'b1;
    in_data  = 32'h55;
    in_ctrl  = 8'h06;
    step();
    chk("fd_d_data", out_data, 32'h55);
    flush   = 1'b1;
    in_data = 32'h66;
    in_ctrl = 8'h07;
    step();
    chk("fd_valid", {31'd0, out_valid}, 32'd0);
    chk("fd_ready", {31'd0, in_ready}, 32'd1);
    chk_cnt("fd_drop_same", flush_drop_count, 4'd2);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fd_no_e", {31'd0, out_valid}, 32'd0);

    // Reset plus flush while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    in_ctrl   = 8'h08;
    step();
    in_data = 32'h88;
    in_ctrl = 8'h09;
    step();
    chk("rf_full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    flush    = 1'b1;
    step();
    chk("rf_valid", {31'd0, out_valid}, 32'd0);
    chk("rf_ctrl", {24'd0, out_ctrl}, {24'd0, BUB});
    chk("rf_data", out_data, 32'd0);
    chk("rf_ready", {31'd0, in_ready}, 32'd1);
    chk_cnt("rf_stall", stall_count, 4'd0);
    chk_cnt("rf_drop", flush_drop_count, 4'd0);
    rst   = 1'b0;
    flush = 1'b0;

    // Stall counter saturation.
    in_valid = 1'b1;
    in_data  = 32'h99;
    in_ctrl  = 8'h0A;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 5) begin
        chk_cnt("sat_mid", stall_count, 4'd5);
      end
    end
    chk_cnt("sat_stall", stall_count, 4'd15);
    chk("sat_data", out_data, 32'h99);
    chk("sat_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("sat_done", {31'd0, out_valid}, 32'd0);
    chk_cnt("sat_hold", stall_count, 4'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
